// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   NOP_INSTR_ENC     : addi x0,x0,0, driven to decode when no instruction is valid
//   RESET_PC_DEFAULT  : default PC after reset
//   fetch_state_t     : fetch FSM encoding (FS_RUN / FS_HALTED)
//   fetch_entry_t     : one fetch-buffer entry {pc, instr}
package instr_fetch_pkg;

  localparam logic [31:0] NOP_INSTR_ENC    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FS_RUN    = 1'b0,
    FS_HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Fetch buffer: small synchronous FIFO holding {pc, instr} words that have
// returned from instruction memory but not yet been taken by decode.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   push      : write wdata this cycle (ignored when full)
//   pop       : drop the head entry this cycle (ignored when empty)
//   flush     : discard all entries; wins over push/pop
//   wdata     : entry to write
//   head      : oldest entry (meaningful only when !empty)
//   count     : number of stored entries
//   empty     : no entries
//   full      : DEPTH entries stored
module instr_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction
// memory (fixed 1-cycle read latency) and buffers returned words so that
// decode stalls never lose a fetch. Handles EX redirects and halting.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   imem_req      : read request this cycle
//   imem_addr     : word-aligned read address (current PC)
//   imem_rdata    : read data, valid the cycle after an accepted imem_req
//   stall_in_if   : decode cannot accept this cycle
//   redirect_in   : taken branch/jump from EX
//   target_in     : redirect target PC
//   halt_in       : halt from a later stage
//   valid_out_if  : instr_out_if/pc_out_if carry a real instruction
//   instr_out_if  : instruction to decode (NOP when not valid)
//   pc_out_if     : PC of instr_out_if (holds last value when not valid)
//   halt_out_if   : fetch is halted (halt_in or misaligned redirect)
//
// IF->ID handshake: an instruction transfers on a cycle where
// valid_out_if=1 and stall_in_if=0. While stall_in_if=1 the presented
// instruction and PC stay stable unless a redirect or halt flushes them.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_ENC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall_in_if,
  input  logic        redirect_in,
  input  logic [31:0] target_in,
  input  logic        halt_in,
  output logic        valid_out_if,
  output logic [31:0] instr_out_if,
  output logic [31:0] pc_out_if,
  output logic        halt_out_if
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic [31:0]   pc_hold;
  logic          inflight;

  logic          issue;
  logic          push;
  logic          pop;
  logic          flush;
  logic [CW:0]   committed;

  fetch_entry_t  head;
  fetch_entry_t  wentry;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;

  assign wentry = '{pc: req_pc, instr: imem_rdata};

  instr_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wentry),
    .head  (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Next state, flush and issue decision.
  // committed = entries that will occupy the buffer once this cycle's pop
  // and the in-flight return are accounted for. Counting the same-cycle pop
  // lets fetch sustain one instruction per cycle with only two entries,
  // while a new request can still never overflow the buffer on return.
  always_comb begin
    state_next = state;
    flush      = 1'b0;
    issue      = 1'b0;
    pop        = !fifo_empty && !stall_in_if;
    committed  = {1'b0, fifo_count} - (CW + 1)'(pop) + (CW + 1)'(inflight);
    case (state)
      FS_RUN: begin
        if (halt_in) begin
          // Halt wins over a simultaneous redirect.
          state_next = FS_HALTED;
          flush      = 1'b1;
        end else if (redirect_in) begin
          flush = 1'b1;
          if (target_in[1:0] != 2'b00) state_next = FS_HALTED;
        end else begin
          issue = !rst && (committed < (CW + 1)'(FIFO_DEPTH))
                  && !(fifo_full && !pop);
        end
      end
      FS_HALTED: flush = 1'b1;
      default:   flush = 1'b1;
    endcase
    // A flush also squashes the word returning this cycle.
    push = inflight && !flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FS_RUN;
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      pc_hold  <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= issue;
      if (issue) begin
        pc     <= pc + 32'd4;
        req_pc <= pc;
      end else if (state == FS_RUN && !halt_in && redirect_in) begin
        pc <= target_in;
      end
      // Remember the last presented PC so pc_out_if holds it when empty.
      if (!fifo_empty) pc_hold <= head.pc;
    end
  end

  assign imem_req     = issue;
  assign imem_addr    = pc;
  assign valid_out_if = !fifo_empty;
  assign instr_out_if = fifo_empty ? NOP_INSTR : head.instr;
  assign pc_out_if    = fifo_empty ? pc_hold : head.pc;
  assign halt_out_if  = (state == FS_HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a per-cycle vector table for the
// main instance plus a wrap-around sequence on a second instance.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [31:0] DATA_KEY = 32'h5A00_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (RESET_PC = 0)
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] target = '0;
  logic        halt = 1'b0;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc_o;
  logic        halt_o;

  // wrap instance (RESET_PC = FFFF_FFF8)
  logic        rst_w = 1'b1;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata = '0;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        w_halt;

  instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .stall_in_if(stall), .redirect_in(redir),
    .target_in(target), .halt_in(halt), .valid_out_if(valid),
    .instr_out_if(instr), .pc_out_if(pc_o), .halt_out_if(halt_o)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2), .NOP_INSTR(NOP)) dut_w (
    .clk(clk), .rst(rst_w), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .stall_in_if(1'b0), .redirect_in(1'b0),
    .target_in(32'h0), .halt_in(1'b0), .valid_out_if(w_valid),
    .instr_out_if(w_instr), .pc_out_if(w_pc), .halt_out_if(w_halt)
  );

  // Instruction memory model: 1-cycle latency, data = address ^ key.
  always @(posedge clk) begin
    imem_rdata <= imem_addr ^ DATA_KEY;
    w_rdata    <= w_addr ^ DATA_KEY;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        chk;
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] target;
    logic        halt;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        halt_o;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic chk, input logic r, input logic s,
                              input logic d, input logic [31:0] t, input logic h,
                              input logic req, input logic [31:0] addr,
                              input logic v, input logic [31:0] pc, input logic ho);
    vec_t x;
    x.chk = chk; x.rst = r; x.stall = s; x.redir = d; x.target = t; x.halt = h;
    x.req = req; x.addr = addr; x.valid = v; x.pc = pc; x.halt_o = ho;
    return x;
  endfunction

  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];

  initial begin
    //              chk rst stl red target         hlt  req addr          v  pc            ho
    // reset state
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        0));
    // streaming, one per cycle
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h4,        0, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h8,        1, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'hC,        1, 32'h4,        0));
    // stall 5 cycles at pc 8: buffer fills, requests stop
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0,   0, 32'h10,       1, 32'h8,        0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0,   0, 32'h10,       1, 32'h8,        0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0,   0, 32'h10,       1, 32'h8,        0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0,   0, 32'h10,       1, 32'h8,        0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0,   0, 32'h10,       1, 32'h8,        0));
    // resume: 8, C, 10, 14 without gaps
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h10,       1, 32'h8,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h14,       1, 32'hC,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h18,       1, 32'h10,       0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h1C,       1, 32'h14,       0));
    // reset mid-fetch, then redirect to 0x100 while 0x10 is in flight
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h4,        0, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h8,        1, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'hC,        1, 32'h4,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h10,       1, 32'h8,        0));
    vecs.push_back(mk(1, 0, 0, 1, 32'h100,      0,   0, 32'h14,       1, 32'hC,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h100,      0, 32'hC,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h104,      0, 32'hC,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h108,      1, 32'h100,      0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h10C,      1, 32'h104,      0));
    // misaligned redirect: halt, sticky, later redirects ignored
    vecs.push_back(mk(1, 0, 0, 1, 32'h102,      0,   0, 32'h110,      1, 32'h108,      0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   0, 32'h102,      0, 32'h108,      1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0,   0, 32'h102,      0, 32'h108,      1));
    vecs.push_back(mk(1, 0, 0, 1, 32'h200,      0,   0, 32'h102,      0, 32'h108,      1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   0, 32'h102,      0, 32'h108,      1));
    // reset out of HALTED, then halt and redirect together (halt wins)
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h4,        0, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h8,        1, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 1, 32'h40,       1,   0, 32'hC,        1, 32'h4,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   0, 32'hC,        0, 32'h4,        1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0,   0, 32'hC,        0, 32'h4,        1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,   1, 32'h4,        0, 32'h0,        0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst    = vecs[i].rst;
      stall  = vecs[i].stall;
      redir  = vecs[i].redir;
      target = vecs[i].target;
      halt   = vecs[i].halt;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("row%0d imem_req", i),  {31'b0, imem_req}, {31'b0, vecs[i].req});
        check($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].addr);
        check($sformatf("row%0d valid", i),     {31'b0, valid}, {31'b0, vecs[i].valid});
        check($sformatf("row%0d pc_out", i),    pc_o, vecs[i].pc);
        check($sformatf("row%0d instr", i),     instr,
              vecs[i].valid ? (vecs[i].pc ^ DATA_KEY) : NOP);
        check($sformatf("row%0d halt_out", i),  {31'b0, halt_o}, {31'b0, vecs[i].halt_o});
      end
    end

    // PC wrap from FFFF_FFF8 on the second instance
    @(negedge clk);
    rst_w = 1'b1;
    @(negedge clk);
    #1;
    check("wrap reset pc_out", w_pc, 32'hFFFF_FFF8);
    check("wrap reset valid", {31'b0, w_valid}, 32'h0);
    check("wrap reset req", {31'b0, w_req}, 32'h0);
    rst_w = 1'b0;
    addr_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    exp_q  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    for (int c = 0; c < 10; c++) begin
      #1;
      if (w_req && addr_q.size() > 0)
        check("wrap imem_addr", w_addr, addr_q.pop_front());
      if (w_valid && exp_q.size() > 0) begin
        check("wrap instr", w_instr, exp_q[0] ^ DATA_KEY);
        check("wrap pc_out", w_pc, exp_q.pop_front());
      end
      @(negedge clk);
    end
    if (addr_q.size() != 0 || exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL wrap_timeout: got %0d addrs %0d pcs outstanding expected 0",
               addr_q.size(), exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
